// File: rtl/invntt_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : invntt_job_scheduler_if
// Brief    : Request/grant and shared-transform-core handshake bundle for the
//            forward/inverse NTT job scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface invntt_job_scheduler_if #(
    parameter int MAX_POLY = 4
);
    localparam int c_idx_w = (MAX_POLY > 1) ? $clog2(MAX_POLY) : 1;

    logic               req_fwd;
    logic               req_inv;
    logic [2:0]         cnt_fwd;
    logic [2:0]         cnt_inv;
    logic               gnt_fwd;
    logic               gnt_inv;
    logic               core_sel;
    logic               core_set;
    logic               core_readin;
    logic               core_cal_en;
    logic               core_readin_ok;
    logic               core_full_in;
    logic               core_full_out;
    logic               core_done;
    logic [c_idx_w-1:0] poly_idx;
    logic               busy;
    logic               job_done_fwd;
    logic               job_done_inv;
    logic               timeout_err;

    // Scheduler side
    modport master (
        input  req_fwd, req_inv, cnt_fwd, cnt_inv,
        input  core_readin_ok, core_full_in, core_full_out, core_done,
        output gnt_fwd, gnt_inv, core_sel, core_set, core_readin, core_cal_en,
        output poly_idx, busy, job_done_fwd, job_done_inv, timeout_err
    );

    // Requesters and transform core side
    modport slave (
        output req_fwd, req_inv, cnt_fwd, cnt_inv,
        output core_readin_ok, core_full_in, core_full_out, core_done,
        input  gnt_fwd, gnt_inv, core_sel, core_set, core_readin, core_cal_en,
        input  poly_idx, busy, job_done_fwd, job_done_inv, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/invntt_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : invntt_job_scheduler
// Brief    : Round-robin scheduler sharing one NTT core between forward and
//            inverse jobs, sequencing each polynomial with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module invntt_job_scheduler #(
    parameter int MAX_POLY = 4,
    parameter int TIMEOUT  = 1023
) (
    input  wire logic              clk,
    input  wire logic              reset,
    invntt_job_scheduler_if.master bus
);
    localparam int                 c_idx_w    = (MAX_POLY > 1) ? $clog2(MAX_POLY) : 1;
    localparam int                 c_wd_w     = 10;
    localparam logic [c_wd_w-1:0]  c_wd_limit = c_wd_w'(TIMEOUT - 1);
    localparam logic [3:0]         c_max_cnt  = 4'(MAX_POLY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_FULL = 3'd2,
        S_COMPUTE   = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_UNLOAD    = 3'd5,
        S_NEXT      = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t              r_state;
    logic                r_last_served;   // 1 = inverse served last
    logic                r_side;          // side of the job in flight
    logic [c_idx_w-1:0]  r_last_idx;
    logic [c_idx_w-1:0]  r_poly_idx;
    logic [c_wd_w-1:0]   r_wd;
    logic                r_gnt_fwd;
    logic                r_gnt_inv;
    logic                r_core_sel;
    logic                r_core_set;
    logic                r_readin;
    logic                r_cal_en;
    logic                r_busy;
    logic                r_done_fwd;
    logic                r_done_inv;
    logic                r_timeout_err;

    logic                w_pick_inv;
    logic [2:0]          w_cnt_raw;
    logic [3:0]          w_cnt_clamped;
    logic [c_idx_w-1:0]  w_last_idx;
    logic                w_waiting;
    logic                w_flag;

    always_comb begin
        w_pick_inv = bus.req_inv && (!bus.req_fwd || !r_last_served);
        w_cnt_raw  = w_pick_inv ? bus.cnt_inv : bus.cnt_fwd;
        if (w_cnt_raw == 3'd0) begin
            w_cnt_clamped = 4'd1;
        end else if ({1'b0, w_cnt_raw} > c_max_cnt) begin
            w_cnt_clamped = c_max_cnt;
        end else begin
            w_cnt_clamped = {1'b0, w_cnt_raw};
        end
        w_last_idx = c_idx_w'(w_cnt_clamped - 4'd1);
    end

    // Each wait state listens to exactly one core flag; all others are ignored.
    always_comb begin
        w_waiting = 1'b0;
        w_flag    = 1'b0;
        case (r_state)
            S_LOAD:      begin w_waiting = 1'b1; w_flag = bus.core_readin_ok; end
            S_WAIT_FULL: begin w_waiting = 1'b1; w_flag = bus.core_full_in;   end
            S_WAIT_DONE: begin w_waiting = 1'b1; w_flag = bus.core_done;      end
            S_UNLOAD:    begin w_waiting = 1'b1; w_flag = bus.core_full_out;  end
            default:     begin w_waiting = 1'b0; w_flag = 1'b0;               end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_served <= 1'b1;
            r_side        <= 1'b0;
            r_last_idx    <= '0;
            r_poly_idx    <= '0;
            r_wd          <= '0;
            r_gnt_fwd     <= 1'b0;
            r_gnt_inv     <= 1'b0;
            r_core_sel    <= 1'b0;
            r_core_set    <= 1'b0;
            r_readin      <= 1'b0;
            r_cal_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_done_fwd    <= 1'b0;
            r_done_inv    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_gnt_fwd  <= 1'b0;
            r_gnt_inv  <= 1'b0;
            r_cal_en   <= 1'b0;
            r_done_fwd <= 1'b0;
            r_done_inv <= 1'b0;
            r_wd       <= '0;

            if (w_waiting && !w_flag) begin
                if (r_wd == c_wd_limit) begin
                    // Core stalled: abandon the job silently but keep fairness.
                    r_timeout_err <= 1'b1;
                    r_state       <= S_IDLE;
                    r_busy        <= 1'b0;
                    r_core_set    <= 1'b0;
                    r_readin      <= 1'b0;
                    r_poly_idx    <= '0;
                    r_last_served <= r_side;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.req_fwd || bus.req_inv) begin
                            r_gnt_fwd  <= !w_pick_inv;
                            r_gnt_inv  <= w_pick_inv;
                            r_side     <= w_pick_inv;
                            r_core_sel <= w_pick_inv;
                            r_last_idx <= w_last_idx;
                            r_poly_idx <= '0;
                            r_busy     <= 1'b1;
                            r_core_set <= 1'b1;
                            r_readin   <= 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_readin <= 1'b0;
                        r_state  <= S_WAIT_FULL;
                    end
                    S_WAIT_FULL: begin
                        r_cal_en <= 1'b1;
                        r_state  <= S_COMPUTE;
                    end
                    S_COMPUTE:   r_state <= S_WAIT_DONE;
                    S_WAIT_DONE: r_state <= S_UNLOAD;
                    S_UNLOAD:    r_state <= S_NEXT;
                    S_NEXT: begin
                        if (r_poly_idx == r_last_idx) begin
                            r_core_set <= 1'b0;
                            r_done_fwd <= !r_side;
                            r_done_inv <= r_side;
                            r_state    <= S_DONE;
                        end else begin
                            r_poly_idx <= r_poly_idx + 1'b1;
                            r_readin   <= 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        r_busy        <= 1'b0;
                        r_poly_idx    <= '0;
                        r_last_served <= r_side;
                        r_state       <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.gnt_fwd      = r_gnt_fwd;
    assign bus.gnt_inv      = r_gnt_inv;
    assign bus.core_sel     = r_core_sel;
    assign bus.core_set     = r_core_set;
    assign bus.core_readin  = r_readin;
    assign bus.core_cal_en  = r_cal_en;
    assign bus.poly_idx     = r_poly_idx;
    assign bus.busy         = r_busy;
    assign bus.job_done_fwd = r_done_fwd;
    assign bus.job_done_inv = r_done_inv;
    assign bus.timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_invntt_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_invntt_job_scheduler
// Brief    : Directed, table-driven bench for the NTT job scheduler with a
//            reactive core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_invntt_job_scheduler;
    localparam int MAX_POLY = 4;
    localparam int TIMEOUT  = 1023;

    typedef struct {
        bit         inv;
        logic [2:0] cnt;
        int         polys;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    invntt_job_scheduler_if #(.MAX_POLY(MAX_POLY)) bus ();

    invntt_job_scheduler #(
        .MAX_POLY (MAX_POLY),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          done_en  = 1'b1;
    bit          stall_p1 = 1'b0;
    bit          seen_cal = 1'b0;
    bit          prev_terr = 1'b0;
    int          cyc = 0;
    int          m_gnt_f = 0, m_gnt_i = 0, m_cal = 0, m_cal_inv = 0;
    int          m_done_f = 0, m_done_i = 0;
    int          m_done_f_cyc = -1, m_gnt_i_cyc = -1, m_cal_cyc = -1, m_terr_cyc = -1;
    logic [15:0] m_seq = '0;

    // Core model and monitor, both on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (bus.gnt_fwd)      m_gnt_f++;
        if (bus.gnt_inv)      begin m_gnt_i++; m_gnt_i_cyc = cyc; end
        if (bus.job_done_fwd) begin m_done_f++; m_done_f_cyc = cyc; end
        if (bus.job_done_inv) m_done_i++;
        if (bus.core_cal_en) begin
            m_cal++;
            if (bus.core_sel) m_cal_inv++;
            m_seq     = {m_seq[13:0], bus.poly_idx};
            m_cal_cyc = cyc;
        end
        if (bus.timeout_err && !prev_terr) m_terr_cyc = cyc;
        prev_terr = bus.timeout_err;
        if (bus.core_readin)      seen_cal = 1'b0;
        else if (bus.core_cal_en) seen_cal = 1'b1;
        bus.core_readin_ok = bus.core_readin;
        bus.core_full_in   = 1'b1;
        bus.core_done      = done_en && seen_cal;
        bus.core_full_out  = !(stall_p1 && bus.poly_idx == 2'd1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [11:0] outs;
        outs = {bus.gnt_fwd, bus.gnt_inv, bus.core_sel, bus.core_set, bus.core_readin,
                bus.core_cal_en, bus.poly_idx, bus.busy, bus.job_done_fwd,
                bus.job_done_inv, bus.timeout_err};
        check(name, int'(outs), 0);
    endtask

    task automatic wait_grant(input bit inv, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (inv ? bus.gnt_inv : bus.gnt_fwd) got = 1'b1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && bus.busy; i++) tick();
    endtask

    task automatic run_job(input bit inv, input logic [2:0] cnt, input int polys, input string tag);
        int          gf0 = m_gnt_f;
        int          gi0 = m_gnt_i;
        int          c0  = m_cal;
        int          ci0 = m_cal_inv;
        int          df0 = m_done_f;
        int          di0 = m_done_i;
        bit          got;
        logic [15:0] exp_seq;
        logic [15:0] mask;
        exp_seq = '0;
        mask    = '0;
        if (inv) begin bus.cnt_inv = cnt; bus.req_inv = 1'b1; end
        else     begin bus.cnt_fwd = cnt; bus.req_fwd = 1'b1; end
        wait_grant(inv, got);
        bus.req_fwd = 1'b0;
        bus.req_inv = 1'b0;
        check({tag, " grant"}, int'(got), 1);
        wait_idle();
        check({tag, " busy_after"}, int'(bus.busy), 0);
        check({tag, " gnt_fwd_pulses"}, m_gnt_f - gf0, inv ? 0 : 1);
        check({tag, " gnt_inv_pulses"}, m_gnt_i - gi0, inv ? 1 : 0);
        check({tag, " cal_pulses"}, m_cal - c0, polys);
        check({tag, " cal_inv_mode"}, m_cal_inv - ci0, inv ? polys : 0);
        check({tag, " done_fwd"}, m_done_f - df0, inv ? 0 : 1);
        check({tag, " done_inv"}, m_done_i - di0, inv ? 1 : 0);
        for (int i = 0; i < polys; i++) begin
            exp_seq = (exp_seq << 2) | 16'(i);
            mask    = (mask << 2) | 16'h3;
        end
        check({tag, " poly_idx_seq"}, int'(m_seq & mask), int'(exp_seq));
    endtask

    initial begin
        vec_t vt [0:6];
        bit   got;
        int   snap, snap2, cal_cyc;

        vt[0] = '{1'b0, 3'd3, 3};
        vt[1] = '{1'b1, 3'd0, 1};
        vt[2] = '{1'b1, 3'd7, 4};
        vt[3] = '{1'b0, 3'd4, 4};
        vt[4] = '{1'b0, 3'd1, 1};
        vt[5] = '{1'b1, 3'd2, 2};
        vt[6] = '{1'b0, 3'd5, 4};

        bus.req_fwd = 1'b0;
        bus.req_inv = 1'b0;
        bus.cnt_fwd = 3'd0;
        bus.cnt_inv = 3'd0;
        repeat (2) tick();
        check_all_zero("reset_outputs");

        // Contention out of reset: forward first, inverse only after forward completes
        bus.cnt_fwd = 3'd1;
        bus.cnt_inv = 3'd1;
        bus.req_fwd = 1'b1;
        bus.req_inv = 1'b1;
        reset = 1'b0;
        snap = m_gnt_i;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (bus.gnt_fwd || bus.gnt_inv) got = 1'b1;
        end
        check("contend first_fwd", int'(bus.gnt_fwd), 1);
        check("contend first_not_inv", int'(bus.gnt_inv), 0);
        check("contend sel_fwd", int'(bus.core_sel), 0);
        bus.req_fwd = 1'b0;
        wait_idle();
        check("contend no_early_gnt_inv", m_gnt_i - snap, 0);
        wait_grant(1'b1, got);
        check("contend gnt_inv", int'(got), 1);
        check("contend sel_inv", int'(bus.core_sel), 1);
        check("contend gnt_inv_after_done", int'(m_gnt_i_cyc > m_done_f_cyc), 1);
        bus.req_inv = 1'b0;
        snap = m_done_i;
        wait_idle();
        check("contend done_inv", m_done_i - snap, 1);

        for (int v = 0; v < 7; v++) begin
            run_job(vt[v].inv, vt[v].cnt, vt[v].polys, $sformatf("vec%0d", v));
        end

        // Watchdog: core never signals done
        done_en = 1'b0;
        snap    = m_done_f;
        snap2   = m_cal;
        bus.cnt_fwd = 3'd1;
        bus.req_fwd = 1'b1;
        wait_grant(1'b0, got);
        bus.req_fwd = 1'b0;
        check("wd grant", int'(got), 1);
        for (int i = 0; i < 20 && m_cal == snap2; i++) tick();
        cal_cyc = m_cal_cyc;
        for (int i = 0; i < TIMEOUT + 50 && !bus.timeout_err; i++) tick();
        check("wd timeout_err", int'(bus.timeout_err), 1);
        check("wd latency", m_terr_cyc - cal_cyc, TIMEOUT + 1);
        check("wd busy_clear", int'(bus.busy), 0);
        check("wd core_set_clear", int'(bus.core_set), 0);
        check("wd no_job_done", m_done_f - snap, 0);
        done_en = 1'b1;
        run_job(1'b0, 3'd2, 2, "post_wd");
        check("wd sticky", int'(bus.timeout_err), 1);

        // Reset while poly 1 is stuck in UNLOAD
        stall_p1 = 1'b1;
        snap  = m_done_i;
        snap2 = m_cal;
        bus.cnt_inv = 3'd3;
        bus.req_inv = 1'b1;
        wait_grant(1'b1, got);
        bus.req_inv = 1'b0;
        for (int i = 0; i < 40 && (m_cal - snap2) < 2; i++) tick();
        repeat (3) tick();
        check("midrst busy", int'(bus.busy), 1);
        check("midrst poly_idx", int'(bus.poly_idx), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("midrst async_outputs");
        tick();
        reset    = 1'b0;
        stall_p1 = 1'b0;
        repeat (2) tick();
        check("midrst no_job_done", m_done_i - snap, 0);
        run_job(1'b1, 3'd2, 2, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
